// File: rtl/ip4_rtl_pkg.sv
// Shared types and FP32 helpers for the ip4 datapath blocks.
// Ordering key maps IEEE754 single to an unsigned integer with the same total order.
package ip4_rtl_pkg;

   typedef enum logic [1:0] {RDC_IDLE, RDC_ACC, RDC_DONE} rdc_st_t;

   localparam int WID_RDC_LEN = 8;
   typedef bit [WID_RDC_LEN-1:0] rdc_len_t;

   function automatic logic fp_is_nan(input logic [31:0] v);
      return (v[30:23] == 8'hFF) && (v[22:0] != 23'd0);
   endfunction

   function automatic logic fp_is_zero(input logic [31:0] v);
      return (v[30:0] == 31'd0);
   endfunction

   // Negative values invert so larger magnitudes sort lower; positives get the top bit set.
   function automatic logic [31:0] fp_key(input logic [31:0] v);
      return v[31] ? ~v : {1'b1, v[30:0]};
   endfunction

endpackage

// File: rtl/ip4_fcmp.sv
// Combinational FP32 comparator: relation flags, min/max select, signalling-NaN status.
// +0 and -0 compare equal; any NaN operand yields uo with lt/eq/gt all low.
module ip4_fcmp
   import ip4_rtl_pkg::*;
(
   input  logic [31:0] op0,
   input  logic [31:0] op1,
   output logic        lt,
   output logic        eq,
   output logic        gt,
   output logic        uo,
   output logic [31:0] max,
   output logic [31:0] min,
   output logic        st0,
   output logic        st1
);

   logic nan0;
   logic nan1;
   logic key_lt;

   always_comb begin
      nan0   = fp_is_nan(op0);
      nan1   = fp_is_nan(op1);
      uo     = nan0 | nan1;
      key_lt = fp_key(op0) < fp_key(op1);
      eq     = !uo && ((op0 == op1) || (fp_is_zero(op0) && fp_is_zero(op1)));
      lt     = !uo && !eq && key_lt;
      gt     = !uo && !eq && !key_lt;
      max    = gt ? op0 : op1;
      min    = lt ? op0 : op1;
      st0    = nan0 && !op0[22];
      st1    = nan1 && !op1[22];
   end

endmodule

// File: rtl/ip4_fcmp_rdc.sv
// Streaming FP32 min/max reduction: one element per cycle in, one result per vector out.
// Result appears the cycle after the last element is accepted and is held until out_rdy.
module ip4_fcmp_rdc
   import ip4_rtl_pkg::*;
#(
   parameter int WID_LEN = WID_RDC_LEN
)
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               op_min,
   input  logic [WID_LEN-1:0] len,
   input  logic               in_vld,
   output logic               in_rdy,
   input  logic [31:0]        in_dat,
   output logic               out_vld,
   input  logic               out_rdy,
   output logic [31:0]        out_dat,
   output logic [WID_LEN-1:0] out_idx,
   output logic               out_uo,
   output logic               out_emp,
   output logic               busy
);

   localparam logic [WID_LEN-1:0] ONE = 1;

   rdc_st_t            st;
   logic               op_min_q;
   logic [WID_LEN-1:0] len_q;
   logic [WID_LEN-1:0] cnt_q;
   logic [WID_LEN-1:0] idx_q;
   logic [31:0]        acc_q;
   logic               have_q;
   logic               uo_q;

   logic               cmp_lt;
   logic               cmp_eq_unused;
   logic               cmp_gt;
   logic               cmp_uo;
   logic [31:0]        cmp_max_unused;
   logic [31:0]        cmp_min_unused;
   logic               cmp_st0_unused;
   logic               cmp_st1_unused;

   logic               xfer;
   logic               take;
   logic [31:0]        acc_n;
   logic [WID_LEN-1:0] idx_n;
   logic               have_n;
   logic               uo_n;

   ip4_fcmp u_cmp (
      .op0 (in_dat),
      .op1 (acc_q),
      .lt  (cmp_lt),
      .eq  (cmp_eq_unused),
      .gt  (cmp_gt),
      .uo  (cmp_uo),
      .max (cmp_max_unused),
      .min (cmp_min_unused),
      .st0 (cmp_st0_unused),
      .st1 (cmp_st1_unused)
   );

   assign in_rdy = (st == RDC_ACC);
   assign busy   = (st != RDC_IDLE);

   // Strict lt/gt means ties never replace, so the lower index wins.
   always_comb begin
      xfer   = in_vld && in_rdy;
      take   = xfer && !cmp_uo && (!have_q || (op_min_q ? cmp_lt : cmp_gt));
      acc_n  = take ? in_dat : acc_q;
      idx_n  = take ? cnt_q  : idx_q;
      have_n = have_q | take;
      uo_n   = uo_q | (xfer && cmp_uo);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st       <= RDC_IDLE;
         op_min_q <= 1'b0;
         len_q    <= '0;
         cnt_q    <= '0;
         idx_q    <= '0;
         acc_q    <= '0;
         have_q   <= 1'b0;
         uo_q     <= 1'b0;
         out_vld  <= 1'b0;
         out_dat  <= '0;
         out_idx  <= '0;
         out_uo   <= 1'b0;
         out_emp  <= 1'b0;
      end else begin
         case (st)
            RDC_IDLE: begin
               if (start) begin
                  op_min_q <= op_min;
                  len_q    <= len;
                  cnt_q    <= '0;
                  idx_q    <= '0;
                  acc_q    <= '0;
                  have_q   <= 1'b0;
                  uo_q     <= 1'b0;
                  if (len == '0) begin
                     st      <= RDC_DONE;
                     out_vld <= 1'b1;
                     out_dat <= '0;
                     out_idx <= '0;
                     out_uo  <= 1'b0;
                     out_emp <= 1'b1;
                  end else begin
                     st <= RDC_ACC;
                  end
               end
            end
            RDC_ACC: begin
               if (xfer) begin
                  acc_q  <= acc_n;
                  idx_q  <= idx_n;
                  have_q <= have_n;
                  uo_q   <= uo_n;
                  cnt_q  <= cnt_q + ONE;
                  if (cnt_q == len_q - ONE) begin
                     st      <= RDC_DONE;
                     out_vld <= 1'b1;
                     out_dat <= acc_n;
                     out_idx <= idx_n;
                     out_uo  <= uo_n;
                     out_emp <= !have_n;
                  end
               end
            end
            RDC_DONE: begin
               if (out_rdy) begin
                  out_vld <= 1'b0;
                  st      <= RDC_IDLE;
               end
            end
            default: st <= RDC_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ip4_fcmp_rdc.sv
// Directed bench for the FP32 min/max reduction engine; inputs driven and outputs sampled on negedge.
module tb_ip4_fcmp_rdc;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        op_min = 1'b0;
   logic [7:0]  len = 8'd0;
   logic        in_vld = 1'b0;
   logic        in_rdy;
   logic [31:0] in_dat = 32'd0;
   logic        out_vld;
   logic        out_rdy = 1'b0;
   logic [31:0] out_dat;
   logic [7:0]  out_idx;
   logic        out_uo;
   logic        out_emp;
   logic        busy;

   int          n_chk = 0;
   int          n_err = 0;
   logic [31:0] vec [0:7];

   ip4_fcmp_rdc dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .op_min  (op_min),
      .len     (len),
      .in_vld  (in_vld),
      .in_rdy  (in_rdy),
      .in_dat  (in_dat),
      .out_vld (out_vld),
      .out_rdy (out_rdy),
      .out_dat (out_dat),
      .out_idx (out_idx),
      .out_uo  (out_uo),
      .out_emp (out_emp),
      .busy    (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic do_start(input logic op, input int n);
      @(negedge clk);
      start  = 1'b1;
      op_min = op;
      len    = 8'(n);
      @(negedge clk);
      start  = 1'b0;
   endtask

   // Feeds vec[0..n-1]; on return we are at the negedge one cycle after the last transfer.
   task automatic feed(input string tag, input int n, input bit bub);
      for (int k = 0; k < n; k++) begin
         if (bub && k > 0) begin
            in_vld = 1'b0;
            @(negedge clk);
         end
         in_vld = 1'b1;
         in_dat = vec[k];
         chk({tag, "_rdy"}, 32'(in_rdy), 32'd1);
         chk({tag, "_novld"}, 32'(out_vld), 32'd0);
         @(negedge clk);
      end
      in_vld = 1'b0;
   endtask

   task automatic check_res(input string tag, input logic [31:0] dat, input logic [7:0] idx,
                            input logic uo, input logic emp);
      chk({tag, "_vld"}, 32'(out_vld), 32'd1);
      chk({tag, "_dat"}, out_dat, dat);
      chk({tag, "_idx"}, 32'(out_idx), 32'(idx));
      chk({tag, "_uo"},  32'(out_uo), 32'(uo));
      chk({tag, "_emp"}, 32'(out_emp), 32'(emp));
      out_rdy = 1'b1;
      @(negedge clk);
      out_rdy = 1'b0;
      chk({tag, "_drop"}, 32'(out_vld), 32'd0);
      chk({tag, "_idle"}, 32'(busy), 32'd0);
   endtask

   initial begin
      #3;
      chk("rst_vld",  32'(out_vld), 32'd0);
      chk("rst_rdy",  32'(in_rdy),  32'd0);
      chk("rst_busy", 32'(busy),    32'd0);
      chk("rst_dat",  out_dat,      32'd0);
      chk("rst_emp",  32'(out_emp), 32'd0);
      #10 rst_n = 1'b1;

      // 1) max over {1.0, -3.0, 2.0, 0.5}
      vec[0] = 32'h3F800000; vec[1] = 32'hC0400000; vec[2] = 32'h40000000; vec[3] = 32'h3F000000;
      do_start(1'b0, 4);
      feed("max4", 4, 1'b0);
      check_res("max4", 32'h40000000, 8'd2, 1'b0, 1'b0);

      // 2) min over the same vector with bubbles
      do_start(1'b1, 4);
      feed("min4b", 4, 1'b1);
      check_res("min4b", 32'hC0400000, 8'd1, 1'b0, 1'b0);

      // 3) NaN skipped, tie keeps lower index; then all-NaN
      vec[0] = 32'h7FC00000; vec[1] = 32'h3F800000; vec[2] = 32'h3F800000;
      do_start(1'b0, 3);
      feed("nan3", 3, 1'b0);
      check_res("nan3", 32'h3F800000, 8'd1, 1'b1, 1'b0);
      vec[0] = 32'h7FC00000; vec[1] = 32'h7F800001;
      do_start(1'b0, 2);
      feed("allnan", 2, 1'b0);
      check_res("allnan", 32'h00000000, 8'd0, 1'b1, 1'b1);

      // 4) empty vector, result held under backpressure while start pulses are ignored
      do_start(1'b0, 0);
      chk("len0_rdy", 32'(in_rdy), 32'd0);
      for (int i = 0; i < 5; i++) begin
         start = 1'b1;
         len   = 8'd3;
         @(negedge clk);
         chk("hold_vld",  32'(out_vld), 32'd1);
         chk("hold_emp",  32'(out_emp), 32'd1);
         chk("hold_dat",  out_dat,      32'd0);
         chk("hold_rdy",  32'(in_rdy),  32'd0);
      end
      start = 1'b0;
      check_res("len0", 32'h00000000, 8'd0, 1'b0, 1'b1);

      // 5) asynchronous reset mid-vector, then a fresh single-element vector
      vec[0] = 32'h3F800000; vec[1] = 32'hC0400000;
      do_start(1'b0, 4);
      feed("abort", 2, 1'b0);
      chk("abort_busy", 32'(busy), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_busy", 32'(busy),    32'd0);
      chk("arst_rdy",  32'(in_rdy),  32'd0);
      chk("arst_emp",  32'(out_emp), 32'd0);
      chk("arst_vld",  32'(out_vld), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      vec[0] = 32'h3F000000;
      do_start(1'b0, 1);
      feed("one", 1, 1'b0);
      check_res("one", 32'h3F000000, 8'd0, 1'b0, 1'b0);

      // 6) min over {+0, -0}; start during the handshake is ignored, next cycle accepted
      vec[0] = 32'h00000000; vec[1] = 32'h80000000;
      do_start(1'b1, 2);
      feed("zero", 2, 1'b0);
      chk("zero_dat", out_dat, 32'h00000000);
      chk("zero_idx", 32'(out_idx), 32'd0);
      out_rdy = 1'b1;
      start   = 1'b1;
      op_min  = 1'b1;
      len     = 8'd2;
      @(negedge clk);
      out_rdy = 1'b0;
      chk("b2b_ign", 32'(busy), 32'd0);
      @(negedge clk);
      start = 1'b0;
      chk("b2b_acc", 32'(busy), 32'd1);
      vec[0] = 32'hBF800000; vec[1] = 32'hC0000000;
      feed("b2b", 2, 1'b0);
      check_res("b2b", 32'hC0000000, 8'd1, 1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
